// File: rtl/dvp_tx_pkg.sv
// Shared types and constants for the DVP frame transmitter.
//   state_t    : frame sequencer states
//   MODE_*     : pixel source selection encodings
//   BAR_*      : the eight RGB565 colour-bar values, left to right
//   cnt_w      : counter width needed to hold values 0..n-1
//   max4       : largest of four counts (sizes the shared line counter)
//   bar_colour : colour-bar index to RGB565
package dvp_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_VSYNC,
      ST_VBACK,
      ST_ACTIVE,
      ST_VFRONT
   } state_t;

   localparam logic [1:0] MODE_EXT   = 2'd0;
   localparam logic [1:0] MODE_BARS  = 2'd1;
   localparam logic [1:0] MODE_GRAD  = 2'd2;
   localparam logic [1:0] MODE_CHECK = 2'd3;

   localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
   localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
   localparam logic [15:0] BAR_CYAN    = 16'h07FF;
   localparam logic [15:0] BAR_GREEN   = 16'h07E0;
   localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
   localparam logic [15:0] BAR_RED     = 16'hF800;
   localparam logic [15:0] BAR_BLUE    = 16'h001F;
   localparam logic [15:0] BAR_BLACK   = 16'h0000;

   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   function automatic logic [15:0] bar_colour(input logic [2:0] idx);
      logic [15:0] c;
      case (idx)
         3'd0:    c = BAR_WHITE;
         3'd1:    c = BAR_YELLOW;
         3'd2:    c = BAR_CYAN;
         3'd3:    c = BAR_GREEN;
         3'd4:    c = BAR_MAGENTA;
         3'd5:    c = BAR_RED;
         3'd6:    c = BAR_BLUE;
         default: c = BAR_BLACK;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// Pixel source and byte serialiser for the DVP transmitter.
// Selects the external pixel or one of the internal test patterns, and
// holds it in a register whose top byte drives the DVP data bus directly.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : capture the selected pixel (cycle before its high byte)
//   shift     : move the low byte into the top byte (high-byte cycle)
//   mode      : pixel source (MODE_*)
//   x, y      : pixel column / active line of the pixel being captured
//   pix_data  : external RGB565 pixel
//   pixel     : registered pixel; pixel[15:8] is the current bus byte,
//               zero whenever neither load nor shift is active
module dvp_pattern_gen
   import dvp_tx_pkg::*;
#(
   parameter int H_VALID = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        shift,
   input  logic [1:0]  mode,
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic [15:0] pix_data,
   output logic [15:0] pixel
);

   localparam int BAR_W = H_VALID / 8;

   logic [15:0] pix_comb;
   logic [15:0] bar_idx;
   logic        unused_y;

   // Only y[5] feeds the checkerboard.
   assign unused_y = ^{y[15:6], y[4:0]};

   always_comb begin
      pix_comb = 16'h0000;
      bar_idx  = x / 16'(BAR_W);
      case (mode)
         MODE_EXT:   pix_comb = pix_data;
         MODE_BARS:  pix_comb = bar_colour(bar_idx[2:0]);
         MODE_GRAD:  pix_comb = {x[4:0], x[5:0], x[4:0]};
         MODE_CHECK: pix_comb = (x[5] ^ y[5]) ? 16'hFFFF : 16'h0000;
         default:    pix_comb = 16'h0000;
      endcase
   end

   // Clearing outside load/shift keeps the bus at 00 during blanking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pixel <= '0;
      else if (load)
         pixel <= pix_comb;
      else if (shift)
         pixel <= {pixel[7:0], 8'h00};
      else
         pixel <= '0;
   end

endmodule

// File: rtl/dvp_frame_tx.sv
// DVP (OV5640-style) video transmitter: vsync / href / 8-bit data at two
// bytes per RGB565 pixel, high byte first.
//   clk        : byte clock
//   rst        : asynchronous active-high reset
//   enable     : frames start (and chain back-to-back) while high
//   mode       : 0 external, 1 colour bars, 2 gradient, 3 checkerboard
//   pix_req    : one-cycle read strobe to the external source (mode 0)
//   pix_data   : external RGB565, valid the cycle after pix_req
//   dvp_vsync  : frame sync, active high
//   dvp_href   : high during active bytes
//   dvp_data   : byte stream, 00 outside href
//   busy       : high from frame start until frame end
//   frame_done : one-cycle pulse on the last clock of a frame
// The sequencer (stage p0) runs three clocks ahead of the bus outputs;
// pix_req leaves after one clock so the external pixel lands in the
// pattern generator register exactly when its high byte is due.
module dvp_frame_tx
   import dvp_tx_pkg::*;
#(
   parameter int H_VALID     = 1024,
   parameter int V_VALID     = 768,
   parameter int H_BLANK     = 64,
   parameter int VSYNC_LINES = 4,
   parameter int V_BACK      = 16,
   parameter int V_FRONT     = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [1:0]  mode,
   output logic        pix_req,
   input  logic [15:0] pix_data,
   output logic        dvp_vsync,
   output logic        dvp_href,
   output logic [7:0]  dvp_data,
   output logic        busy,
   output logic        frame_done
);

   localparam int LINE_CLKS = 2 * H_VALID + H_BLANK;
   localparam int HW = cnt_w(LINE_CLKS);
   localparam int VW = cnt_w(max4(VSYNC_LINES, V_BACK, V_VALID, V_FRONT));
   localparam logic [HW-1:0] H_LAST = HW'(LINE_CLKS - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(2 * H_VALID);

   state_t        state_q, state_d;
   logic [HW-1:0] h_cnt_q;
   logic [VW-1:0] v_cnt_q;
   logic [VW-1:0] v_last;
   logic [1:0]    mode_q;
   logic          line_end, v_end, frame_end;

   logic          vsync_p0, href_p0, hi_p0, lo_p0, req_p0, busy_p0;
   logic [15:0]   x_p0, y_p0;
   logic          vsync_p1, href_p1, hi_p1, lo_p1, busy_p1, done_p1;
   logic [15:0]   x_p1, y_p1;
   logic          vsync_p2, href_p2, hi_p2, lo_p2, busy_p2, done_p2;
   logic [15:0]   x_p2, y_p2;
   logic [15:0]   pixel;
   logic          unused_lo;

   // Next-state logic: every state lasts a whole number of lines.
   always_comb begin
      line_end  = (h_cnt_q == H_LAST);
      v_last    = '0;
      frame_end = 1'b0;
      state_d   = state_q;
      case (state_q)
         ST_VSYNC:  v_last = VW'(VSYNC_LINES - 1);
         ST_VBACK:  v_last = VW'(V_BACK - 1);
         ST_ACTIVE: v_last = VW'(V_VALID - 1);
         ST_VFRONT: v_last = VW'(V_FRONT - 1);
         default:   v_last = '0;
      endcase
      v_end = (v_cnt_q == v_last);
      case (state_q)
         ST_IDLE:   if (enable) state_d = ST_VSYNC;
         ST_VSYNC:  if (line_end && v_end) state_d = ST_VBACK;
         ST_VBACK:  if (line_end && v_end) state_d = ST_ACTIVE;
         ST_ACTIVE: if (line_end && v_end) state_d = ST_VFRONT;
         ST_VFRONT: begin
            if (line_end && v_end) begin
               frame_end = 1'b1;
               state_d   = enable ? ST_VSYNC : ST_IDLE;
            end
         end
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         mode_q  <= MODE_EXT;
      end else begin
         state_q <= state_d;
         if (state_q == ST_IDLE || line_end)
            h_cnt_q <= '0;
         else
            h_cnt_q <= h_cnt_q + 1'b1;
         if (state_q == ST_IDLE || (line_end && v_end))
            v_cnt_q <= '0;
         else if (line_end)
            v_cnt_q <= v_cnt_q + 1'b1;
         // Mode is sampled once per frame, on every entry to VSYNC.
         if (state_d == ST_VSYNC && state_q != ST_VSYNC)
            mode_q <= mode;
      end
   end

   // Stage p0: decode the sequencer position.
   always_comb begin
      vsync_p0 = (state_q == ST_VSYNC);
      href_p0  = (state_q == ST_ACTIVE) && (h_cnt_q < H_ACT);
      hi_p0    = href_p0 && !h_cnt_q[0];
      lo_p0    = href_p0 && h_cnt_q[0];
      req_p0   = hi_p0 && (mode_q == MODE_EXT);
      busy_p0  = (state_q != ST_IDLE);
      x_p0     = 16'(h_cnt_q >> 1);
      y_p0     = 16'(v_cnt_q);
   end

   // Stage p1: pix_req leaves here, two clocks ahead of its high byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vsync_p1 <= 1'b0;
         href_p1  <= 1'b0;
         hi_p1    <= 1'b0;
         lo_p1    <= 1'b0;
         busy_p1  <= 1'b0;
         done_p1  <= 1'b0;
         pix_req  <= 1'b0;
      end else begin
         vsync_p1 <= vsync_p0;
         href_p1  <= href_p0;
         hi_p1    <= hi_p0;
         lo_p1    <= lo_p0;
         busy_p1  <= busy_p0;
         done_p1  <= frame_end;
         pix_req  <= req_p0;
      end
   end

   always_ff @(posedge clk) begin
      x_p1 <= x_p0;
      y_p1 <= y_p0;
   end

   // Stage p2: pix_data is valid; the pattern generator captures it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vsync_p2 <= 1'b0;
         href_p2  <= 1'b0;
         hi_p2    <= 1'b0;
         lo_p2    <= 1'b0;
         busy_p2  <= 1'b0;
         done_p2  <= 1'b0;
      end else begin
         vsync_p2 <= vsync_p1;
         href_p2  <= href_p1;
         hi_p2    <= hi_p1;
         lo_p2    <= lo_p1;
         busy_p2  <= busy_p1;
         done_p2  <= done_p1;
      end
   end

   always_ff @(posedge clk) begin
      x_p2 <= x_p1;
      y_p2 <= y_p1;
   end

   dvp_pattern_gen #(
      .H_VALID (H_VALID)
   ) u_pattern_gen (
      .clk      (clk),
      .rst      (rst),
      .load     (hi_p2),
      .shift    (lo_p2),
      .mode     (mode_q),
      .x        (x_p2),
      .y        (y_p2),
      .pix_data (pix_data),
      .pixel    (pixel)
   );

   // Stage p3: bus outputs, all registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dvp_vsync  <= 1'b0;
         dvp_href   <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         dvp_vsync  <= vsync_p2;
         dvp_href   <= href_p2;
         busy       <= busy_p2;
         frame_done <= done_p2;
      end
   end

   // The low byte reaches the bus through the generator's shift.
   assign dvp_data  = pixel[15:8];
   assign unused_lo = ^pixel[7:0];

endmodule
